// File: rtl/counter_pkg.sv
// Shared constants, direction type and slice-count helper for the sliced counter.
package counter_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    function automatic int slice_count(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/counter_slice.sv
// One 4-bit counter slice with async clear, sync load, forced value and lookahead step enable.
module counter_slice
    import counter_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_n_clr,
    input  logic               i_n_load,
    input  logic [SLICE_W-1:0] i_preset,
    input  logic               i_step,
    input  dir_t               i_dir,
    input  logic               i_force,
    input  logic [SLICE_W-1:0] i_force_val,
    output logic [SLICE_W-1:0] o_q,
    output logic               o_all_ones,
    output logic               o_all_zeros
);

    localparam logic [SLICE_W-1:0] ONE = SLICE_W'(1);

    logic [SLICE_W-1:0] r_q;

    // Load beats the wrap force, which beats an ordinary step.
    always_ff @(posedge i_clk or negedge i_n_clr) begin
        if (!i_n_clr) begin
            r_q <= '0;
        end else if (!i_n_load) begin
            r_q <= i_preset;
        end else if (i_force) begin
            r_q <= i_force_val;
        end else if (i_step) begin
            if (i_dir == DIR_UP) begin
                r_q <= r_q + ONE;
            end else begin
                r_q <= r_q - ONE;
            end
        end
    end

    assign o_q         = r_q;
    assign o_all_ones  = &r_q;
    assign o_all_zeros = ~|r_q;

endmodule

// File: rtl/counter_n.sv
// WIDTH-bit up/down modulus counter built from 4-bit slices with lookahead enables.
// Optional build macro COUNTER_SATURATE_EN: hold at the terminal value instead of wrapping.
module counter_n
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             N_CLR,
    input  logic             ENP,
    input  logic             ENT,
    input  logic             UP,
    input  logic [WIDTH-1:0] MODULUS,
    input  logic [WIDTH-1:0] PRESET,
    input  logic             N_LOAD,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             WRAP
);

    localparam int NS = slice_count(WIDTH);

`ifdef COUNTER_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    generate
        if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_bad_width
            $error("counter_n: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    dir_t             w_dir;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_force_val;
    logic [NS-1:0]    w_ones;
    logic [NS-1:0]    w_zeros;
    logic [NS-1:0]    w_flag;
    logic [NS-1:0]    w_step;
    logic             w_en;
    logic             w_term;
    logic             w_force;
    logic             w_count;
    logic             r_wrap;

    always_comb begin
        w_dir       = UP ? DIR_UP : DIR_DOWN;
        w_en        = ENP && ENT;
        w_term      = (w_dir == DIR_UP) ? (w_q == MODULUS) : (w_q == '0);
        w_force     = w_en && w_term && !SATURATE;
        w_count     = w_en && !w_term;
        w_flag      = (w_dir == DIR_UP) ? w_ones : w_zeros;
        w_force_val = (w_dir == DIR_UP) ? '0 : MODULUS;
    end

    // Each slice's step is the AND of all lower slice flags, not a ripple through Q.
    genvar k;
    generate
        for (k = 0; k < NS; k++) begin : g_slice
            if (k == 0) begin : g_lsb
                assign w_step[k] = w_count;
            end else begin : g_upper
                assign w_step[k] = w_count && (&w_flag[k-1:0]);
            end

            counter_slice u_slice (
                .i_clk       (CLK),
                .i_n_clr     (N_CLR),
                .i_n_load    (N_LOAD),
                .i_preset    (PRESET[k*SLICE_W +: SLICE_W]),
                .i_step      (w_step[k]),
                .i_dir       (w_dir),
                .i_force     (w_force),
                .i_force_val (w_force_val[k*SLICE_W +: SLICE_W]),
                .o_q         (w_q[k*SLICE_W +: SLICE_W]),
                .o_all_ones  (w_ones[k]),
                .o_all_zeros (w_zeros[k])
            );
        end
    endgenerate

    always_ff @(posedge CLK or negedge N_CLR) begin
        if (!N_CLR) begin
            r_wrap <= 1'b0;
        end else if (!N_LOAD) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_en && w_term;
        end
    end

    assign Q    = w_q;
    assign RCO  = ENT && w_term;
    assign WRAP = r_wrap;

endmodule

// File: tb/tb_counter_n.sv
// Directed plus randomized bench for counter_n at WIDTH=8 and WIDTH=16 against a rule-level model.
module tb_counter_n;

`ifdef COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        N_CLR;
    logic        a_enp, a_ent, a_up, a_nload, a_rco, a_wrap;
    logic [7:0]  a_mod, a_pre, a_q;
    logic        b_enp, b_ent, b_up, b_nload, b_rco, b_wrap;
    logic [15:0] b_mod, b_pre, b_q;

    logic [15:0] ma_q, mb_q;
    logic        ma_w, mb_w;
    int          n_vec = 0;
    int          n_err = 0;

    counter_n #(.WIDTH(8)) dut_a (
        .CLK(CLK), .N_CLR(N_CLR), .ENP(a_enp), .ENT(a_ent), .UP(a_up),
        .MODULUS(a_mod), .PRESET(a_pre), .N_LOAD(a_nload),
        .Q(a_q), .RCO(a_rco), .WRAP(a_wrap)
    );

    counter_n #(.WIDTH(16)) dut_b (
        .CLK(CLK), .N_CLR(N_CLR), .ENP(b_enp), .ENT(b_ent), .UP(b_up),
        .MODULUS(b_mod), .PRESET(b_pre), .N_LOAD(b_nload),
        .Q(b_q), .RCO(b_rco), .WRAP(b_wrap)
    );

    function automatic void ref_next(input int w, input logic [15:0] q, input logic [15:0] md,
                                     input logic [15:0] pre, input logic nload, input logic enp,
                                     input logic ent, input logic up,
                                     output logic [15:0] nq, output logic nw);
        int unsigned m;
        int unsigned qi;
        m  = 32'd1 << w;
        qi = 32'(q);
        if (!nload) begin
            nq = pre;
            nw = 1'b0;
        end else if (enp && ent) begin
            if (up ? (q == md) : (q == 16'd0)) begin
                nw = 1'b1;
                nq = SAT ? q : (up ? 16'd0 : md);
            end else begin
                nw = 1'b0;
                nq = 16'((up ? qi + 1 : qi + m - 1) % m);
            end
        end else begin
            nq = q;
            nw = 1'b0;
        end
    endfunction

    function automatic logic ref_rco(input logic [15:0] q, input logic [15:0] md,
                                     input logic ent, input logic up);
        return ent && (up ? (q == md) : (q == 16'd0));
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("a_q",    16'(a_q),    ma_q);
        chk("a_wrap", 16'(a_wrap), 16'(ma_w));
        chk("a_rco",  16'(a_rco),  16'(ref_rco(ma_q, 16'(a_mod), a_ent, a_up)));
        chk("b_q",    b_q,         mb_q);
        chk("b_wrap", 16'(b_wrap), 16'(mb_w));
        chk("b_rco",  16'(b_rco),  16'(ref_rco(mb_q, b_mod, b_ent, b_up)));
    endtask

    task automatic tick();
        logic [15:0] na, nb;
        logic        wa, wb;
        ref_next(8,  ma_q, 16'(a_mod), 16'(a_pre), a_nload, a_enp, a_ent, a_up, na, wa);
        ref_next(16, mb_q, b_mod, b_pre, b_nload, b_enp, b_ent, b_up, nb, wb);
        @(posedge CLK);
        #1;
        if (!N_CLR) begin
            ma_q = '0; ma_w = 1'b0; mb_q = '0; mb_w = 1'b0;
        end else begin
            ma_q = na; ma_w = wa; mb_q = nb; mb_w = wb;
        end
        check_all();
    endtask

    task automatic async_clear();
        #3;
        N_CLR = 1'b0;
        #1;
        ma_q = '0; ma_w = 1'b0; mb_q = '0; mb_w = 1'b0;
        check_all();
    endtask

    initial begin
        N_CLR   = 1'b0;
        a_enp = 1'b0; a_ent = 1'b1; a_up = 1'b1; a_nload = 1'b1; a_mod = 8'd9; a_pre = 8'd0;
        b_enp = 1'b0; b_ent = 1'b0; b_up = 1'b1; b_nload = 1'b1; b_mod = 16'h0100; b_pre = 16'd0;
        ma_q = '0; ma_w = 1'b0; mb_q = '0; mb_w = 1'b0;
        #2;
        check_all();
        tick();
        N_CLR = 1'b1;

        // BCD-style count 0..9 with wrap
        a_enp = 1'b1;
        repeat (12) tick();

        // Down count with wrap to MODULUS
        a_mod = 8'd5; a_up = 1'b0; a_pre = 8'd2; a_nload = 1'b0;
        tick();
        a_nload = 1'b1;
        repeat (4) tick();

        // Load beats count enables
        a_up = 1'b1; a_mod = 8'd9; a_pre = 8'hA5; a_nload = 1'b0;
        tick();
        a_nload = 1'b1;

        // ENP gating at terminal, then ENT gating of RCO
        a_pre = 8'd9; a_nload = 1'b0;
        tick();
        a_nload = 1'b1; a_enp = 1'b0;
        repeat (2) tick();
        a_ent = 1'b0;
        tick();
        a_ent = 1'b1;

        // Async clear mid-count at 8'h37
        a_mod = 8'hFF; a_pre = 8'h36; a_nload = 1'b0;
        tick();
        a_nload = 1'b1; a_enp = 1'b1;
        tick();
        async_clear();
        tick();
        N_CLR = 1'b1;
        repeat (3) tick();

        // 16-bit out-of-range rollover and slice-boundary lookahead
        a_enp = 1'b0;
        b_pre = 16'hFFFE; b_nload = 1'b0; b_up = 1'b1; b_ent = 1'b1; b_enp = 1'b1;
        tick();
        b_nload = 1'b1;
        repeat (260) tick();
        b_enp = 1'b0;

        // Terminal behaviour at MODULUS=3, then load clears WRAP
        a_mod = 8'd3; a_up = 1'b1; a_pre = 8'd0; a_nload = 1'b0; a_enp = 1'b1;
        tick();
        a_nload = 1'b1;
        repeat (6) tick();
        a_nload = 1'b0;
        tick();
        a_nload = 1'b1;

        // Randomized traffic on both counters
        for (int i = 0; i < 400; i++) begin
            a_nload = ($urandom_range(0, 11) != 0);
            a_enp   = ($urandom_range(0, 3) != 0);
            a_ent   = ($urandom_range(0, 3) != 0);
            a_up    = 1'($urandom_range(0, 1));
            a_mod   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            a_pre   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            b_nload = ($urandom_range(0, 11) != 0);
            b_enp   = ($urandom_range(0, 3) != 0);
            b_ent   = ($urandom_range(0, 3) != 0);
            b_up    = 1'($urandom_range(0, 1));
            b_mod   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
            b_pre   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
            tick();
            if (i % 100 == 99) begin
                async_clear();
                N_CLR = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/counter_n.md
Name: counter_n

Overview:
- Parametrised synchronous up/down counter; next generation of the team's 4-bit loadable binary counter.
- Generalised to WIDTH bits, with direction control, a programmable terminal value (MODULUS), and a registered wrap pulse.
- Built from cascaded 4-bit slices with carry lookahead.
- Used for program counters, microcode step counters and baud/timer dividers where a non-power-of-two period is needed.

Parameters:
- WIDTH, 8, counter width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).

Ports:
- CLK  input  1  clock, rising edge.
- N_CLR  input  1  reset, asynchronous, active-low; clears all state.
- ENP  input  1  count enable (parallel); must be high to count.
- ENT  input  1  count enable (trickle); must be high to count; also gates RCO.
- UP  input  1  direction: 1 = increment, 0 = decrement.
- MODULUS  input  WIDTH  terminal value; count period is MODULUS+1.
- PRESET  input  WIDTH  load value.
- N_LOAD  input  1  synchronous load, active-low.
- Q  output  WIDTH  current count.
- RCO  output  1  combinational carry out, for chaining.
- WRAP  output  1  registered one-cycle pulse following a wrap.

Behaviour:
- Reset: N_CLR low forces Q=0 and WRAP=0 immediately, independent of CLK, and holds them while low. RCO follows its equation and reads ENT && (UP ? MODULUS==0 : 1).
- Clocked priority on each rising CLK edge with N_CLR high:
  1. N_LOAD==0: Q<=PRESET, WRAP<=0. Load ignores ENP/ENT and may load any value, including >MODULUS.
  2. ENP && ENT: count step, as defined below.
  3. Otherwise: Q holds, WRAP<=0.
- Terminal condition: TERM = UP ? (Q==MODULUS) : (Q==0).
- Count step, up: TERM gives Q<=0, WRAP<=1; else Q<=Q+1 mod 2^WIDTH, WRAP<=0.
- Count step, down: TERM gives Q<=MODULUS, WRAP<=1; else Q<=Q-1, WRAP<=0.
- Out-of-range Q (Q>MODULUS, e.g. after load):
  - Up: counts naturally to 2^WIDTH-1, then to 0. No WRAP, no RCO on that rollover.
  - Down: counts down normally to 0.
- MODULUS==0: up mode holds Q=0 and pulses WRAP on every enabled cycle. Down mode behaves identically.
- MODULUS or UP changing mid-count takes effect on the next edge; no internal copy is kept.
- RCO = ENT && TERM, combinational; independent of ENP and N_LOAD.
- Chaining: the next counter's ENT is driven from RCO.
- Slice carries: each 4-bit slice's carry/borrow enable is lookahead (AND of lower slices' all-ones/all-zeros and ENP&&ENT), not rippled through Q, for a single-level enable path.
- N_CLR deasserting in the same delta as a CLK rise: the edge is not counted; Q stays 0.

Optional Feature:
- Macro COUNTER_SATURATE_EN.
- Defined: on TERM with ENP && ENT, Q holds (no wrap) and WRAP<=1, and WRAP stays 1 on every further enabled cycle at TERM. Load or reset leaves saturation. RCO is unchanged.
- Undefined: wrap behaviour as above.

Decomposition:
- Package counter_pkg:
  - localparam SLICE_W=4.
  - typedef enum logic {DIR_DOWN=0, DIR_UP=1} dir_t.
  - function slice_count(WIDTH) returning WIDTH/SLICE_W.
- Sub-module counter_slice:
  - One 4-bit register with async N_CLR.
  - Inputs: load/preset nibble, step-enable, UP, force value (wrap target nibble).
  - Outputs: nibble, all-ones flag, all-zeros flag.
- counter_n generates WIDTH/4 slices, computes lookahead enables, TERM, RCO and the WRAP flop.

Test Plan:
- Reset: N_CLR low mid-count at Q=8'h37 -> Q=0, WRAP=0 before next CLK edge; held while low; counting resumes from 0 after release.
- BCD up: WIDTH=8, MODULUS=9, UP=1, ENP=ENT=1 for 12 edges from 0 -> Q 1..9,0,1,2.
  - RCO high only while Q==9.
  - WRAP high exactly the cycle after 9->0.
- Down wrap: MODULUS=8'd5, UP=0, PRESET=2, load then 4 enabled edges -> Q 2,1,0,5,4; WRAP pulses after 0->5.
- Load priority and gating:
  - N_LOAD=0, PRESET=8'hA5, ENP=ENT=1 -> Q=8'hA5 next edge, no increment.
  - ENP=0, ENT=1 at Q==MODULUS -> Q stable, RCO=1.
  - ENT=0 -> RCO=0.
- Out-of-range / WIDTH=16 lookahead: MODULUS=16'h0100, load 16'hFFFE, UP=1 -> 16'hFFFF, 16'h0000 with no WRAP. Then count 255->256 crosses a slice boundary correctly, and 256->0 asserts WRAP.
- COUNTER_SATURATE_EN: MODULUS=3, UP=1 from 0, 6 enabled edges -> Q 1,2,3,3,3,3; WRAP=1 from the 4th edge onward; load PRESET=0 clears WRAP.
